exp3_addsub: RTL and testbench

- Registered, mode-selectable binary adder/subtractor for the experiment-3 arithmetic block.
- Four operating modes: half-adder, full-adder, half-subtractor and full-subtractor, over a WIDTH-bit ripple chain. The default is a single bit.
- Inputs are sampled on each rising clock edge. Results appear one cycle later, tagged with a valid flag.

---
 rtl/exp3_addsub.sv | 103 ++++++++++
 tb/tb_exp3_addsub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exp3_addsub.sv
// Registered half/full adder-subtractor over a WIDTH-cell ripple chain, one-cycle latency.
// Optional signed-overflow output is enabled by defining ADDSUB_OVERFLOW_EN.
module exp3_addsub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode_addsub,
  input  logic             mode_halffull,
  input  logic [WIDTH-1:0] signal_a,
  input  logic [WIDTH-1:0] signal_b,
  input  logic             carryborrow_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sumdiff,
  output logic             carryborrow_out
`ifdef ADDSUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] add_cell(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic c);
    return {(~a & b) | (c & ~(a ^ b)), a ^ b ^ c};
  endfunction

  logic [WIDTH:0]   chain_s;
  logic [WIDTH-1:0] result_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] sumdiff_r;
  logic             carryborrow_out_r;

  // Ripple chain; half mode forces the chain input low so carryborrow_in has no effect.
  always_comb begin
    chain_s    = '0;
    result_s   = '0;
    chain_s[0] = carryborrow_in & mode_halffull;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_addsub) begin
        {chain_s[i+1], result_s[i]} = sub_cell(signal_a[i], signal_b[i], chain_s[i]);
      end else begin
        {chain_s[i+1], result_s[i]} = add_cell(signal_a[i], signal_b[i], chain_s[i]);
      end
    end
  end

  // Result registers: reset wins, results hold while no request is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r       <= 1'b0;
      sumdiff_r         <= '0;
      carryborrow_out_r <= 1'b0;
    end else if (in_valid) begin
      out_valid_r       <= 1'b1;
      sumdiff_r         <= result_s;
      carryborrow_out_r <= chain_s[WIDTH];
    end else begin
      out_valid_r       <= 1'b0;
      sumdiff_r         <= sumdiff_r;
      carryborrow_out_r <= carryborrow_out_r;
    end
  end

  assign out_valid       = out_valid_r;
  assign sumdiff         = sumdiff_r;
  assign carryborrow_out = carryborrow_out_r;

`ifdef ADDSUB_OVERFLOW_EN
  logic overflow_s;
  logic overflow_r;

  // Two's-complement overflow: carry mismatch into/out of the MSB for add, sign rule for subtract.
  always_comb begin
    overflow_s = 1'b0;
    if (mode_addsub) begin
      overflow_s = (signal_a[WIDTH-1] ^ signal_b[WIDTH-1]) & (result_s[WIDTH-1] ^ signal_a[WIDTH-1]);
    end else begin
      overflow_s = chain_s[WIDTH] ^ chain_s[WIDTH-1];
    end
  end

  // Overflow register shares the timing and reset behaviour of sumdiff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (in_valid) begin
      overflow_r <= overflow_s;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_exp3_addsub.sv
// Scoreboard bench for exp3_addsub: WIDTH=1 and WIDTH=4 instances, directed vectors.
// Overflow checks are compiled in when ADDSUB_OVERFLOW_EN is defined.
module tb_exp3_addsub;

  typedef struct packed {
    logic [3:0] sd;
    logic       co;
    logic       ov;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv1 = 1'b0, as1 = 1'b0, hf1 = 1'b0, ci1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       ov1_valid, co1;
  logic [0:0] sd1;

  logic       iv4 = 1'b0, as4 = 1'b0, hf4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       ov4_valid, co4;
  logic [3:0] sd4;
`ifdef ADDSUB_OVERFLOW_EN
  logic       ovf1, ovf4;
`endif

  res_t q1[$];
  res_t q4[$];
  res_t h1 = '0;
  res_t h4 = '0;
  logic rq = 1'b0;
  logic vq1 = 1'b0;
  logic vq4 = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [1:0] fa_exp [8];
  logic [1:0] fs_exp [8];

  always #5 clk = ~clk;

  exp3_addsub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .mode_addsub(as1), .mode_halffull(hf1),
    .signal_a(a1), .signal_b(b1), .carryborrow_in(ci1),
    .out_valid(ov1_valid), .sumdiff(sd1), .carryborrow_out(co1)
`ifdef ADDSUB_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  exp3_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .mode_addsub(as4), .mode_halffull(hf4),
    .signal_a(a4), .signal_b(b4), .carryborrow_in(ci4),
    .out_valid(ov4_valid), .sumdiff(sd4), .carryborrow_out(co4)
`ifdef ADDSUB_OVERFLOW_EN
    , .overflow(ovf4)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which edges accept a request (and whether reset was active), seen by the monitor.
  always @(posedge clk) begin
    rq  <= rst_n;
    vq1 <= iv1 & rst_n;
    vq4 <= iv4 & rst_n;
  end

  // Monitor: pop the expected result whenever an accepted request should be presented.
  always @(negedge clk) begin
    chk("u1_out_valid", 8'(ov1_valid), 8'(vq1));
    chk("u4_out_valid", 8'(ov4_valid), 8'(vq4));
    if (!rq) begin
      h1 = '0;
      h4 = '0;
    end else begin
      if (vq1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_queue: got a result, expected none pending");
        end else begin
          h1 = q1.pop_front();
        end
      end
      if (vq4) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL u4_queue: got a result, expected none pending");
        end else begin
          h4 = q4.pop_front();
        end
      end
    end
    chk("u1_sumdiff", 8'(sd1), 8'(h1.sd[0]));
    chk("u1_cbo", 8'(co1), 8'(h1.co));
    chk("u4_sumdiff", 8'(sd4), 8'(h4.sd));
    chk("u4_cbo", 8'(co4), 8'(h4.co));
`ifdef ADDSUB_OVERFLOW_EN
    chk("u4_overflow", 8'(ovf4), 8'(h4.ov));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic drive1(input logic as_i, input logic hf_i, input logic a_i, input logic b_i,
                        input logic ci_i, input logic [1:0] exp_i);
    res_t r;
    iv1 = 1'b1; as1 = as_i; hf1 = hf_i; a1 = a_i; b1 = b_i; ci1 = ci_i;
    r.sd = {3'b000, exp_i[0]};
    r.co = exp_i[1];
    r.ov = 1'b0;
    if (rst_n) q1.push_back(r);
  endtask

  task automatic drive4(input logic as_i, input logic hf_i, input logic [3:0] a_i,
                        input logic [3:0] b_i, input logic ci_i, input logic [3:0] sd_i,
                        input logic co_i, input logic ovf_i);
    res_t r;
    iv4 = 1'b1; as4 = as_i; hf4 = hf_i; a4 = a_i; b4 = b_i; ci4 = ci_i;
    r.sd = sd_i;
    r.co = co_i;
    r.ov = ovf_i;
    if (rst_n) q4.push_back(r);
  endtask

  initial begin
    logic [2:0] v;
    fa_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    fs_exp = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    // Reset held for two edges with live requests: they must be dropped.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
      drive4(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b1;

    // WIDTH=1 full add then full subtract sweeps, back to back.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(1'b0, 1'b1, v[2], v[1], v[0], fa_exp[i]);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(1'b1, 1'b1, v[2], v[1], v[0], fs_exp[i]);
      tick();
    end

    // WIDTH=1 half modes with carry/borrow-in held high (ignored).
    drive1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10); tick();
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11); tick();
    drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01); tick();
    drive1(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01); tick();

    // WIDTH=4 vectors: {sd, cbo, overflow} computed by hand.
    drive4(1'b0, 1'b1, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0); tick();
    drive4(1'b1, 1'b1, 4'h3, 4'h5, 1'b1, 4'hD, 1'b1, 1'b0); tick();
    drive4(1'b0, 1'b0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1); tick();
    drive4(1'b1, 1'b0, 4'h8, 4'h1, 1'b1, 4'h7, 1'b0, 1'b1); tick();
    drive4(1'b0, 1'b0, 4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b0); tick();
    drive4(1'b0, 1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1); tick();
    drive4(1'b1, 1'b1, 4'h5, 4'h5, 1'b1, 4'hF, 1'b1, 1'b0); tick();
    drive4(1'b1, 1'b1, 4'hA, 4'h3, 1'b0, 4'h7, 1'b0, 1'b1); tick();
    drive4(1'b0, 1'b0, 4'h2, 4'h3, 1'b1, 4'h5, 1'b0, 1'b0); tick();

    // Idle for three cycles: outputs must hold.
    tick(); tick(); tick();

    // Back-to-back requests with a one-edge reset in the middle.
    drive1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    drive4(1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1); tick();
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
    drive4(1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 4'hF, 1'b1, 1'b0); tick();
    rst_n = 1'b0;
    drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    drive4(1'b0, 1'b1, 4'hE, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0); tick();
    rst_n = 1'b1;
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    drive4(1'b0, 1'b1, 4'h6, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1); tick();
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    drive4(1'b1, 1'b1, 4'hC, 4'h4, 1'b1, 4'h7, 1'b0, 1'b1); tick();
    tick(); tick();

    chk("u1_drained", 8'(q1.size()), 8'd0);
    chk("u4_drained", 8'(q4.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
